regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (wEn/addrD/dataD) between two writeback sources:
//  ALU (port A) and load/store unit (port B). Uses valid/ready handshakes with round-robin priority.
//  The granted write is registered for exactly one cycle and drives the register file directly.

---
 rtl/regfile_wb_arbiter.sv | 81 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A) and LSU (B).
// The granted request is registered for one cycle and drives wEn/addrD/dataD directly.
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wEn,
    output logic [ADDR_W-1:0] addrD,
    output logic [DATA_W-1:0] dataD,
    output logic              last_grant,
    output logic [CNT_W-1:0]  contend
);

    typedef enum logic {PRI_A, PRI_B} pri_t;

    pri_t state, state_next;
    logic tie;

    assign tie = a_valid & b_valid & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PRI_A;
        else     state <= state_next;
    end

    // Readies depend only on valid/state/stall, so at most one can be high.
    always_comb begin
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        state_next = state;
        if (!rst && !stall) begin
            a_ready = a_valid & (~b_valid | (state == PRI_A));
            b_ready = b_valid & (~a_valid | (state == PRI_B));
        end
        if (a_ready)      state_next = PRI_B;
        else if (b_ready) state_next = PRI_A;
    end

    // Output stage: one-cycle registered write; x0 completes the handshake but never writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wEn        <= 1'b0;
            addrD      <= '0;
            dataD      <= '0;
            last_grant <= 1'b1;
        end else if (a_ready) begin
            wEn        <= (a_addr != '0);
            addrD      <= a_addr;
            dataD      <= a_data;
            last_grant <= 1'b0;
        end else if (b_ready) begin
            wEn        <= (b_addr != '0);
            addrD      <= b_addr;
            dataD      <= b_data;
            last_grant <= 1'b1;
        end else begin
            wEn        <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contend <= '0;
        end else if (tie && (contend != {CNT_W{1'b1}})) begin
            contend <= contend + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized check of regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              wEn;
    logic [ADDR_W-1:0] addrD;
    logic [DATA_W-1:0] dataD;
    logic              last_grant;
    logic [CNT_W-1:0]  contend;

    int checks;
    int errors;

    // Behavioural model: who wins the next tie, what the write port shows, how many ties seen.
    int              m_pref;   // 0 = A wins a tie, 1 = B wins a tie
    logic            m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic            m_last;
    int              m_cnt;
    int              last_g;   // 0 none, 1 A, 2 B
    int              cnt_before;

    regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .wEn(wEn), .addrD(addrD), .dataD(dataD),
        .last_grant(last_grant), .contend(contend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pref = 0;
        m_wen  = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_last = 1'b1;
        m_cnt  = 0;
        last_g = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".wEn"},        64'(wEn),        64'(m_wen));
        chk({tag, ".addrD"},      64'(addrD),      64'(m_addr));
        chk({tag, ".dataD"},      64'(dataD),      64'(m_data));
        chk({tag, ".last_grant"}, 64'(last_grant), 64'(m_last));
        chk({tag, ".contend"},    64'(contend),    64'(m_cnt));
    endtask

    // Called at posedge+1 with inputs already set; returns at the following posedge+1.
    task automatic cycle(input string tag);
        int g;
        #4;
        g = 0;
        if (!rst && !stall) begin
            if (a_valid && b_valid) g = (m_pref == 0) ? 1 : 2;
            else if (a_valid)       g = 1;
            else if (b_valid)       g = 2;
        end
        chk({tag, ".a_ready"}, 64'(a_ready), 64'(g == 1));
        chk({tag, ".b_ready"}, 64'(b_ready), 64'(g == 2));
        @(posedge clk);
        #1;
        if (g == 1) begin
            m_wen = (a_addr != 0); m_addr = a_addr; m_data = a_data; m_last = 1'b0; m_pref = 1;
        end else if (g == 2) begin
            m_wen = (b_addr != 0); m_addr = b_addr; m_data = b_data; m_last = 1'b1; m_pref = 0;
        end else begin
            m_wen = 1'b0;
        end
        if (a_valid && b_valid && !stall && m_cnt < CNT_MAX) m_cnt++;
        check_outputs(tag);
        last_g = g;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        model_reset();
        rst     = 1'b1;
        stall   = 1'b0;
        a_valid = 1'b1;
        a_addr  = 5'd3;
        a_data  = 32'h1234_5678;
        b_valid = 1'b0;
        b_addr  = '0;
        b_data  = '0;

        // Reset holds off a waiting requester
        #12;
        chk("rst.a_ready", 64'(a_ready), 64'(0));
        chk("rst.b_ready", 64'(b_ready), 64'(0));
        check_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("rst_release");
        chk("rst_release.addr3", 64'(addrD), 64'(3));
        a_valid = 1'b0;
        cycle("rst_idle");

        // Lone A, then idle
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
        cycle("loneA");
        chk("loneA.data", 64'(dataD), 64'h0000_0000_DEAD_BEEF);
        a_valid = 1'b0;
        cycle("loneA_after");
        chk("loneA_after.wEn", 64'(wEn), 64'(0));

        // Lone B so that the next tie goes to A
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hB0B0_0009;
        cycle("loneB");
        b_valid = 1'b0;
        cycle("loneB_after");

        // Persistent tie: A then B, one contention cycle
        cnt_before = m_cnt;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hAAAA_0001;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hBBBB_0002;
        cycle("tie1");
        chk("tie1.addr", 64'(addrD), 64'(1));
        a_valid = 1'b0;
        cycle("tie2");
        chk("tie2.addr", 64'(addrD), 64'(2));
        b_valid = 1'b0;
        cycle("tie3");
        cycle("tie4");
        chk("tie.contend_delta", 64'(contend), 64'(cnt_before + 1));

        // x0 write from B: handshake completes, no write, next tie to A
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF;
        cycle("x0");
        chk("x0.wEn", 64'(wEn), 64'(0));
        b_valid = 1'b0;
        cycle("x0_after");
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h0000_0007;
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h0000_0008;
        cycle("x0_tie");
        chk("x0_tie.last_grant", 64'(last_grant), 64'(0));
        a_valid = 1'b0;
        cycle("x0_tieB");
        b_valid = 1'b0;

        // Stall with both requesting
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h0000_000A;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'h0000_000B;
        stall = 1'b1;
        cnt_before = m_cnt;
        for (int i = 0; i < 3; i++) cycle("stall");
        chk("stall.contend_hold", 64'(contend), 64'(cnt_before));
        chk("stall.wEn", 64'(wEn), 64'(0));
        stall = 1'b0;
        cycle("unstall");
        if (last_g == 1) a_valid = 1'b0; else b_valid = 1'b0;
        cycle("unstall2");
        a_valid = 1'b0; b_valid = 1'b0;
        cycle("unstall3");

        // Saturation: 20 tie cycles, granted source re-presents a fresh nonzero write
        a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd12; b_addr = 5'd13;
        for (int i = 0; i < 20; i++) begin
            cycle("sat");
            if (last_g == 1) begin a_addr = 5'($urandom_range(1, 31)); a_data = $urandom; end
            if (last_g == 2) begin b_addr = 5'($urandom_range(1, 31)); b_data = $urandom; end
        end
        chk("sat.contend", 64'(contend), 64'(CNT_MAX));
        chk("sat.wEn_before_rst", 64'(wEn), 64'(1));

        // Asynchronous reset mid-cycle drops the pending write
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.wEn", 64'(wEn), 64'(0));
        chk("async_rst.contend", 64'(contend), 64'(0));
        chk("async_rst.a_ready", 64'(a_ready), 64'(0));
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic honouring the hold-until-ready rule
        for (int i = 0; i < 300; i++) begin
            if (!a_valid || last_g == 1) begin
                a_valid = 1'($urandom_range(0, 1));
                a_addr  = 5'($urandom);
                a_data  = $urandom;
            end
            if (!b_valid || last_g == 2) begin
                b_valid = 1'($urandom_range(0, 1));
                b_addr  = 5'($urandom);
                b_data  = $urandom;
            end
            stall = ($urandom_range(0, 4) == 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
